// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues word requests to instruction
// memory, buffers in-order responses and hands them to decode, flushing on redirect.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pcplus4
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  // fetch state
  logic [31:0]   fetch_pc_r;
  logic [CW-1:0] occ_r;
  logic [CW-1:0] inflight_r;
  logic [CW-1:0] drop_r;

  // decode-side FIFO and request PC tag FIFO
  logic [31:0]   instr_q_r [DEPTH];
  logic [31:0]   pc_q_r    [DEPTH];
  logic [31:0]   pcp4_q_r  [DEPTH];
  logic [31:0]   tag_q_r   [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] tag_rd_r;
  logic [AW-1:0] tag_wr_r;

  // per-cycle events
  logic          deq_s;
  logic          req_fire_s;
  logic          push_s;
  logic          credit_ok_s;
  logic [CW:0]   demand_s;
  logic [CW-1:0] occ_nxt_s;
  logic [CW-1:0] inflight_nxt_s;
  logic [CW-1:0] rsp_cnt_s;
  logic [31:0]   rsp_pc_s;

  // Credit check, handshakes and counter next-values
  always_comb begin
    deq_s          = (occ_r != CNT_ZERO) & dec_ready;
    // outstanding requests reserve FIFO space, so a push can never overflow
    demand_s       = {1'b0, occ_r} + {1'b0, inflight_r} - {{CW{1'b0}}, deq_s};
    credit_ok_s    = (demand_s < DEPTH_W);
    imem_req_valid = ~reset & ~redirect & credit_ok_s;
    req_fire_s     = imem_req_valid & imem_req_ready;
    push_s         = imem_rsp_valid & (drop_r == CNT_ZERO) & ~redirect;
    rsp_cnt_s      = {{AW{1'b0}}, imem_rsp_valid};
    occ_nxt_s      = occ_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, deq_s};
    inflight_nxt_s = inflight_r + {{AW{1'b0}}, req_fire_s} - rsp_cnt_s;
    rsp_pc_s       = tag_q_r[tag_rd_r];
  end

  // Control state: fetch PC, pointers, occupancy and in-flight/drop counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_r <= RESET_PC;
      occ_r      <= CNT_ZERO;
      inflight_r <= CNT_ZERO;
      drop_r     <= CNT_ZERO;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      tag_rd_r   <= '0;
      tag_wr_r   <= '0;
    end else if (redirect) begin
      // a response arriving now is discarded along with everything still in flight
      fetch_pc_r <= redirect_pc & 32'hFFFF_FFFC;
      occ_r      <= CNT_ZERO;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      inflight_r <= inflight_r - rsp_cnt_s;
      drop_r     <= inflight_r - rsp_cnt_s;
      if (imem_rsp_valid) begin
        tag_rd_r <= tag_rd_r + PTR_ONE;
      end
    end else begin
      occ_r      <= occ_nxt_s;
      inflight_r <= inflight_nxt_s;
      if (req_fire_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
        tag_wr_r   <= tag_wr_r + PTR_ONE;
      end
      if (imem_rsp_valid) begin
        tag_rd_r <= tag_rd_r + PTR_ONE;
        if (drop_r != CNT_ZERO) begin
          drop_r <= drop_r - CNT_ONE;
        end
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage: request PC tags and decoded-side entries {instr, pc, pc+4}
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q_r[i] <= 32'h0000_0000;
        pc_q_r[i]    <= 32'h0000_0000;
        pcp4_q_r[i]  <= 32'h0000_0000;
        tag_q_r[i]   <= 32'h0000_0000;
      end
    end else begin
      if (req_fire_s) begin
        tag_q_r[tag_wr_r] <= fetch_pc_r;
      end
      if (push_s) begin
        instr_q_r[wr_ptr_r] <= imem_rsp_data;
        pc_q_r[wr_ptr_r]    <= rsp_pc_s;
        pcp4_q_r[wr_ptr_r]  <= rsp_pc_s + 32'd4;
      end
    end
  end

  // Outputs come straight from registers; no response-to-decode combinational path
  assign imem_req_addr = fetch_pc_r;
  assign dec_valid     = (occ_r != CNT_ZERO);
  assign dec_instr     = instr_q_r[rd_ptr_r];
  assign dec_pc        = pc_q_r[rd_ptr_r];
  assign dec_pcplus4   = pcp4_q_r[rd_ptr_r];

endmodule
